// File: rtl/neur_seq_ctrl.sv
// ----------------------------------------------------------------------------
// neur_seq_ctrl -- sequencing controller for a bit-serial neural MAC decoder.
//
// Fetches one weight word into a hold register and streams input words
// against it for PPW decoder phases per weight word (PPW = 4 for
// mode[1:0] = 00/10, 2 for 01/11). The lane sum returned by the decoder is
// accumulated into a signed ACC_W-bit result. When a job ends off a 4-phase
// boundary, a short flush keeps the decoder enabled until its phase wraps to
// 0, so the next job starts aligned.
//
// Configuration macro:
//   NEUR_SEQ_SAT_EN  defined   -> accumulator saturates to signed max/min
//                    undefined -> accumulator wraps modulo 2^ACC_W
//
// Ports:
//   clk_i, rst_ni                      clock, synchronous active-low reset
//   start_i, mode_i, len_i             job start, precision mode, word count
//   busy_o                             job active (RUN, FLUSH or DONE)
//   w_valid_i/w_ready_o/w_data_i       weight-word stream
//   x_valid_i/x_ready_o/x_data_i       input-word stream
//   dec_enable_o, dec_mode_o           decoder phase advance, registered mode
//   dec_weights_o, dec_inputs_o        decoder operands (0 when not enabled)
//   lane_sum_i                         signed decoder lane sum, same cycle
//   res_valid_o/res_ready_i/res_o      result handshake
// ----------------------------------------------------------------------------
module neur_seq_ctrl #(
    parameter int unsigned ACC_W = 32,
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [2:0]       mode_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    input  logic             w_valid_i,
    output logic             w_ready_o,
    input  logic [31:0]      w_data_i,
    input  logic             x_valid_i,
    output logic             x_ready_o,
    input  logic [31:0]      x_data_i,
    output logic             dec_enable_o,
    output logic [2:0]       dec_mode_o,
    output logic [31:0]      dec_weights_o,
    output logic [31:0]      dec_inputs_o,
    input  logic [31:0]      lane_sum_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [ACC_W-1:0] res_o
);

    typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

    state_e state_q, state_d;

    logic [1:0]       phase_q, phase_d;
    logic [2:0]       mode_q, mode_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             w_full_q, w_full_d;
    logic [31:0]      w_hold_q, w_hold_d;
    logic [ACC_W-1:0] acc_q, acc_d;

    logic             ppw_two;
    logic             last_sub;
    logic             compute;
    logic             word_done;
    logic             final_word;
    logic             start_job;
    logic             w_take;
    logic             w_hs;
    logic [1:0]       phase_next;
    logic [ACC_W-1:0] acc_sum;
    logic [ACC_W-1:0] lane_ext;

    // ------------------------------------------------------------------
    // Shared decode
    // ------------------------------------------------------------------
    assign ppw_two    = mode_q[0];
    // Jobs always start at phase 0 and PPW divides 4, so the sub-phase of
    // the current word is the low bits of the shared phase counter.
    assign last_sub   = ppw_two ? phase_q[0] : (phase_q == 2'd3);
    assign compute    = (state_q == StRun) && w_full_q && x_valid_i;
    assign word_done  = compute && last_sub;
    assign final_word = (rem_q == LEN_W'(1));
    assign start_job  = (state_q == StIdle) && start_i && (len_i != '0);
    assign phase_next = phase_q + 2'd1;

    // The first weight word is taken together with start so computation can
    // begin on the very first RUN cycle. During RUN the register refills in
    // the same cycle its last phase completes, except after the final word.
    assign w_take = start_job ||
                    ((state_q == StRun) && (!w_full_q || (word_done && !final_word)));
    assign w_hs   = w_take && w_valid_i;

    // ------------------------------------------------------------------
    // Accumulator arithmetic
    // ------------------------------------------------------------------
    assign lane_ext = ACC_W'($signed(lane_sum_i));

`ifdef NEUR_SEQ_SAT_EN
    logic [ACC_W:0] sum_wide;

    always_comb begin
        sum_wide = {acc_q[ACC_W-1], acc_q} + {lane_ext[ACC_W-1], lane_ext};
        acc_sum  = sum_wide[ACC_W-1:0];
        // Overflow shows up as a mismatch between the extended sign bit and
        // the result sign bit; the extended bit gives the true direction.
        if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
            acc_sum = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                      : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
`else
    assign acc_sum = acc_q + lane_ext;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = (len_i != '0) ? StRun : StDone;
                end
            end
            StRun: begin
                if (word_done && final_word) begin
                    state_d = (phase_next != 2'd0) ? StFlush : StDone;
                end
            end
            StFlush: begin
                if (phase_next == 2'd0) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (res_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Everything is held at 0 while reset is asserted.
    // ------------------------------------------------------------------
    always_comb begin
        busy_o        = 1'b0;
        w_ready_o     = 1'b0;
        x_ready_o     = 1'b0;
        dec_enable_o  = 1'b0;
        dec_mode_o    = 3'd0;
        dec_weights_o = 32'd0;
        dec_inputs_o  = 32'd0;
        res_valid_o   = 1'b0;
        res_o         = '0;
        if (rst_ni) begin
            busy_o       = (state_q != StIdle);
            w_ready_o    = w_take;
            x_ready_o    = compute;
            dec_enable_o = compute || (state_q == StFlush);
            dec_mode_o   = mode_q;
            if (compute) begin
                dec_weights_o = w_hold_q;
                dec_inputs_o  = x_data_i;
            end
            if (state_q == StDone) begin
                res_valid_o = 1'b1;
                res_o       = acc_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath next state
    // ------------------------------------------------------------------
    always_comb begin
        phase_d  = phase_q;
        mode_d   = mode_q;
        rem_d    = rem_q;
        w_full_d = w_full_q;
        w_hold_d = w_hold_q;
        acc_d    = acc_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    mode_d = mode_i;
                    rem_d  = len_i;
                    acc_d  = '0;
                end
            end
            StRun: begin
                if (compute) begin
                    phase_d = phase_next;
                    acc_d   = acc_sum;
                    if (last_sub) begin
                        rem_d    = rem_q - LEN_W'(1);
                        w_full_d = 1'b0;
                    end
                end
            end
            StFlush: begin
                phase_d = phase_next;
            end
            default: ;
        endcase

        // A refill in the releasing cycle overrides the release.
        if (w_hs) begin
            w_hold_d = w_data_i;
            w_full_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            phase_q  <= 2'd0;
            mode_q   <= 3'd0;
            rem_q    <= '0;
            w_full_q <= 1'b0;
            w_hold_q <= 32'd0;
            acc_q    <= '0;
        end else begin
            phase_q  <= phase_d;
            mode_q   <= mode_d;
            rem_q    <= rem_d;
            w_full_q <= w_full_d;
            w_hold_q <= w_hold_d;
            acc_q    <= acc_d;
        end
    end

endmodule
